// File: rtl/ifid_reg_pkg.sv
// Shared definitions for the IF/ID pipeline register: bubble encoding, PC step,
// watchdog state encoding and the per-edge update decode.
package ifid_reg_pkg;

  // Encoding placed in the instruction slot on flush and reset.
  localparam logic [31:0] IFID_NOP_INSTR = 32'h0000_0000;

  // Distance between a fetched PC and its PC+4.
  localparam int PC_STEP = 4;

  // Watchdog state encoding (kept as plain constants for older tool flows).
  localparam logic [0:0] WD_RUN     = 1'b0;
  localparam logic [0:0] WD_TRIPPED = 1'b1;

  // What the pipeline slot does on a given edge.
  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_HOLD  = 2'd1,
    ACT_FLUSH = 2'd2
  } ifidAct_e;

  // Flush beats hold, and hold beats load.
  function automatic ifidAct_e decodeAct(input logic flush, input logic write);
    ifidAct_e act;
    if (flush) begin
      act = ACT_FLUSH;
    end else if (!write) begin
      act = ACT_HOLD;
    end else begin
      act = ACT_LOAD;
    end
    return act;
  endfunction

endpackage

// File: rtl/ifid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear. It stops at all-ones rather
// than wrapping, so a debug read never confuses a large count with a small one.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Clear wins over a same-cycle increment; increment is ignored at saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Captures PC+4 and the fetched instruction, honours
// the hazard-unit write enable (stall) and the fetch-stage flush (NOP bubble),
// and keeps stall/flush event counters plus a stuck-stall watchdog for debug.
//
// Watchdog states:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   WD_RUN     | counting consecutive stall cycles, no error reported
//   WD_TRIPPED | a stall lasted STALL_LIMIT cycles; STALLERR held until clear
module ifid_reg
  import ifid_reg_pkg::*;
#(
  parameter int            DW          = 32,
  parameter logic [DW-1:0] NOP_INSTR   = DW'(IFID_NOP_INSTR),
  parameter int            CW          = 16,
  parameter int            STALL_LIMIT = 64
) (
  input  logic          CLOCK,
  input  logic          RESET,
  input  logic [DW-1:0] IFID_inPC4,
  input  logic [DW-1:0] IFID_inINSTR,
  input  logic          IFID_inWRITE,
  input  logic          IFID_inFLUSH,
  input  logic          IFID_inCNTCLR,
  output logic [DW-1:0] IFID_outPC4,
  output logic [DW-1:0] IFID_outPC,
  output logic [DW-1:0] IFID_outINSTR,
  output logic          IFID_outVALID,
  output logic [CW-1:0] IFID_outSTALLS,
  output logic [CW-1:0] IFID_outFLUSHES,
  output logic          IFID_outSTALLERR
);

  // Consecutive-stall count only needs to reach STALL_LIMIT, where it parks.
  localparam int             SRW       = $clog2(STALL_LIMIT + 1);
  localparam logic [SRW-1:0] RUN_LIMIT = SRW'(STALL_LIMIT);

  ifidAct_e       act;
  logic [DW-1:0]  pc4Q;
  logic [DW-1:0]  instrQ;
  logic           validQ;
  logic [SRW-1:0] stallRun;
  logic [SRW-1:0] stallRunNext;
  logic [0:0]     wdState;
  logic [0:0]     wdNext;

  assign act = decodeAct(IFID_inFLUSH, IFID_inWRITE);

  // Pipeline slot: flush inserts a bubble, hold keeps the slot, load captures.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      pc4Q   <= '0;
      instrQ <= NOP_INSTR;
      validQ <= 1'b0;
    end else begin
      unique case (act)
        ACT_FLUSH: begin
          pc4Q   <= '0;
          instrQ <= NOP_INSTR;
          validQ <= 1'b0;
        end
        ACT_LOAD: begin
          pc4Q   <= IFID_inPC4;
          instrQ <= IFID_inINSTR;
          validQ <= 1'b1;
        end
        default: begin
          pc4Q   <= pc4Q;
          instrQ <= instrQ;
          validQ <= validQ;
        end
      endcase
    end
  end

  // Event counters; the clear is applied inside so it overrides an increment.
  sat_counter #(.W(CW)) uStallCnt (
    .clk   (CLOCK),
    .rst_n (RESET),
    .clr   (IFID_inCNTCLR),
    .inc   (act == ACT_HOLD),
    .cnt   (IFID_outSTALLS)
  );

  sat_counter #(.W(CW)) uFlushCnt (
    .clk   (CLOCK),
    .rst_n (RESET),
    .clr   (IFID_inCNTCLR),
    .inc   (act == ACT_FLUSH),
    .cnt   (IFID_outFLUSHES)
  );

  // Next consecutive-stall count: grows on hold up to the limit, drops to zero
  // on any load or flush, and clears outright on CNTCLR.
  always_comb begin
    stallRunNext = stallRun;
    if (IFID_inCNTCLR) begin
      stallRunNext = '0;
    end else begin
      unique case (act)
        ACT_HOLD: begin
          if (stallRun != RUN_LIMIT) begin
            stallRunNext = stallRun + SRW'(1);
          end
        end
        default: stallRunNext = '0;
      endcase
    end
  end

  // Watchdog next state: trips on the edge where the run reaches the limit and
  // only CNTCLR (or reset) brings it back.
  always_comb begin
    wdNext = wdState;
    if (IFID_inCNTCLR) begin
      wdNext = WD_RUN;
    end else if ((wdState == WD_RUN) && (stallRunNext == RUN_LIMIT)) begin
      wdNext = WD_TRIPPED;
    end
  end

  // Watchdog registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      stallRun <= '0;
      wdState  <= WD_RUN;
    end else begin
      stallRun <= stallRunNext;
      wdState  <= wdNext;
    end
  end

  assign IFID_outPC4      = pc4Q;
  assign IFID_outINSTR    = instrQ;
  assign IFID_outVALID    = validQ;
  assign IFID_outPC       = validQ ? (pc4Q - DW'(PC_STEP)) : '0;
  assign IFID_outSTALLERR = (wdState == WD_TRIPPED);

endmodule

// File: tb/tb_ifid_reg.sv
// Directed bench for ifid_reg, built with CW=4 and STALL_LIMIT=4 so counter
// saturation and the watchdog trip are reachable in a few cycles.
module tb_ifid_reg;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock;
  logic          reset;
  logic [DW-1:0] inPc4;
  logic [DW-1:0] inInstr;
  logic          inWrite;
  logic          inFlush;
  logic          inCntClr;
  logic [DW-1:0] outPc4;
  logic [DW-1:0] outPc;
  logic [DW-1:0] outInstr;
  logic          outValid;
  logic [CW-1:0] outStalls;
  logic [CW-1:0] outFlushes;
  logic          outStallErr;

  int vectors = 0;
  int miscompares = 0;

  ifid_reg #(
    .DW          (DW),
    .NOP_INSTR   (32'h0000_0000),
    .CW          (CW),
    .STALL_LIMIT (4)
  ) dut (
    .CLOCK            (clock),
    .RESET            (reset),
    .IFID_inPC4       (inPc4),
    .IFID_inINSTR     (inInstr),
    .IFID_inWRITE     (inWrite),
    .IFID_inFLUSH     (inFlush),
    .IFID_inCNTCLR    (inCntClr),
    .IFID_outPC4      (outPc4),
    .IFID_outPC       (outPc),
    .IFID_outINSTR    (outInstr),
    .IFID_outVALID    (outValid),
    .IFID_outSTALLS   (outStalls),
    .IFID_outFLUSHES  (outFlushes),
    .IFID_outSTALLERR (outStallErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling and driving.
  task automatic stepClk();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    inPc4    = '0;
    inInstr  = '0;
    inWrite  = 1'b0;
    inFlush  = 1'b0;
    inCntClr = 1'b0;
    #12;
    chkVec("rst pc4",     outPc4, 32'h0);
    chkVec("rst instr",   outInstr, 32'h0);
    chkVec("rst valid",   {31'd0, outValid}, 32'd0);
    chkVec("rst pc",      outPc, 32'h0);
    chkVec("rst stalls",  {28'd0, outStalls}, 32'd0);
    chkVec("rst flushes", {28'd0, outFlushes}, 32'd0);
    chkVec("rst stallerr", {31'd0, outStallErr}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Plain load.
    inPc4 = 32'h0000_0104; inInstr = 32'h8C02_0004; inWrite = 1'b1;
    stepClk();
    chkVec("load pc4",   outPc4, 32'h0000_0104);
    chkVec("load pc",    outPc, 32'h0000_0100);
    chkVec("load instr", outInstr, 32'h8C02_0004);
    chkVec("load valid", {31'd0, outValid}, 32'd1);

    // Three stall cycles with changing inputs: slot must hold.
    inWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inPc4 = 32'h0000_0200 + 32'(i * 4); inInstr = 32'hDEAD_0000 + 32'(i);
      stepClk();
    end
    chkVec("stall pc4",    outPc4, 32'h0000_0104);
    chkVec("stall pc",     outPc, 32'h0000_0100);
    chkVec("stall instr",  outInstr, 32'h8C02_0004);
    chkVec("stall valid",  {31'd0, outValid}, 32'd1);
    chkVec("stall count",  {28'd0, outStalls}, 32'd3);
    chkVec("stall noerr",  {31'd0, outStallErr}, 32'd0);

    // Flush wins over hold.
    inFlush = 1'b1;
    stepClk();
    chkVec("flush instr",   outInstr, 32'h0);
    chkVec("flush pc4",     outPc4, 32'h0);
    chkVec("flush valid",   {31'd0, outValid}, 32'd0);
    chkVec("flush pc",      outPc, 32'h0);
    chkVec("flush count",   {28'd0, outFlushes}, 32'd1);
    chkVec("flush stalls",  {28'd0, outStalls}, 32'd3);
    inFlush = 1'b0;

    // Watchdog: four consecutive stalls trip it on the fourth edge.
    for (int i = 0; i < 3; i++) stepClk();
    chkVec("wd before trip", {31'd0, outStallErr}, 32'd0);
    stepClk();
    chkVec("wd trip",        {31'd0, outStallErr}, 32'd1);
    chkVec("wd stalls",      {28'd0, outStalls}, 32'd7);
    inPc4 = 32'h0000_0200; inInstr = 32'h1234_5678; inWrite = 1'b1;
    stepClk();
    chkVec("wd sticky",      {31'd0, outStallErr}, 32'd1);
    chkVec("wd load pc",     outPc, 32'h0000_01FC);
    chkVec("wd load valid",  {31'd0, outValid}, 32'd1);
    inCntClr = 1'b1;
    stepClk();
    chkVec("clr stallerr",   {31'd0, outStallErr}, 32'd0);
    chkVec("clr stalls",     {28'd0, outStalls}, 32'd0);
    chkVec("clr flushes",    {28'd0, outFlushes}, 32'd0);
    chkVec("clr keeps pc4",  outPc4, 32'h0000_0200);
    inCntClr = 1'b0;

    // Stall counter saturation, then clear together with a stall.
    inWrite = 1'b0;
    for (int i = 0; i < 20; i++) stepClk();
    chkVec("sat stalls",     {28'd0, outStalls}, 32'd15);
    chkVec("sat stallerr",   {31'd0, outStallErr}, 32'd1);
    inCntClr = 1'b1;
    stepClk();
    chkVec("clr+stall cnt",  {28'd0, outStalls}, 32'd0);
    chkVec("clr+stall err",  {31'd0, outStallErr}, 32'd0);
    chkVec("clr+stall pc4",  outPc4, 32'h0000_0200);
    inCntClr = 1'b0;

    // Flush counter saturation.
    inFlush = 1'b1;
    for (int i = 0; i < 17; i++) stepClk();
    chkVec("sat flushes",    {28'd0, outFlushes}, 32'd15);
    chkVec("sat fl stalls",  {28'd0, outStalls}, 32'd0);
    inFlush = 1'b0;

    // Build up live state, then assert reset between edges.
    inPc4 = 32'h0000_0300; inInstr = 32'hAABB_CCDD; inWrite = 1'b1;
    stepClk();
    inWrite = 1'b0;
    for (int i = 0; i < 4; i++) stepClk();
    chkVec("pre-rst valid",  {31'd0, outValid}, 32'd1);
    chkVec("pre-rst err",    {31'd0, outStallErr}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chkVec("mid rst pc4",     outPc4, 32'h0);
    chkVec("mid rst pc",      outPc, 32'h0);
    chkVec("mid rst instr",   outInstr, 32'h0);
    chkVec("mid rst valid",   {31'd0, outValid}, 32'd0);
    chkVec("mid rst stalls",  {28'd0, outStalls}, 32'd0);
    chkVec("mid rst flushes", {28'd0, outFlushes}, 32'd0);
    chkVec("mid rst err",     {31'd0, outStallErr}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    stepClk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
